// File: rtl/lsu_data_memory.sv
// Byte/half/word data memory for the LSU. It takes valid/ready requests, returns
// in-order responses after a fixed latency, and zeroes its contents after reset.
module lsu_data_memory #(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_we;

  logic [31:0]      mem [DEPTH_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == S_CLEAR);
  assign req_ready = (state_q == S_IDLE) & ~rst;

  logic             accept;
  logic [1:0]       size;
  logic [IDX_W-1:0] req_idx;
  logic             out_of_range, misaligned, bad_f3, req_err;

  assign accept  = req_valid & req_ready;
  assign size    = req_funct3[1:0];
  assign req_idx = req_addr[IDX_W+1:2];

  // Every address bit above the array span takes part in the range check.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign misaligned = ((size == 2'd1) & req_addr[0]) | ((size == 2'd2) & (|req_addr[1:0]));
  assign bad_f3     = req_we ? (req_funct3[2] | (size == 2'd3))
                             : ((size == 2'd3) | (req_funct3 == 3'b110));
  assign req_err    = out_of_range | misaligned | bad_f3;

  logic             wr_en;
  logic [3:0]       wr_be;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_be   = 4'h0;
    wr_idx  = req_idx;
    wr_data = req_wdata;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_be   = 4'hF;
      wr_idx  = clr_idx_q;
      wr_data = '0;
    end else if (accept & req_we & ~req_err) begin
      wr_en = 1'b1;
      unique case (size)
        2'd0: begin
          wr_be   = 4'b0001 << req_addr[1:0];
          wr_data = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{req_wdata[15:0]}};
        end
        default: wr_be = 4'hF;
      endcase
    end
  end

  logic [31:0] s0_word_q;

  // NOTE: the array has no reset so it maps onto block RAM; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (accept) s0_word_q <= mem[req_idx];
  end

  logic       s0_valid_q, s0_err_q, s0_load_q;
  logic [2:0] s0_f3_q;
  logic [1:0] s0_lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_load_q  <= 1'b0;
      s0_f3_q    <= '0;
      s0_lane_q  <= '0;
    end else begin
      s0_valid_q <= accept;
      s0_err_q   <= accept & req_err;
      s0_load_q  <= accept & ~req_we;
      s0_f3_q    <= req_funct3;
      s0_lane_q  <= req_addr[1:0];
    end
  end

  logic [7:0]  s0_byte;
  logic [15:0] s0_half;
  logic [31:0] s0_fmt;

  always_comb begin
    s0_byte = s0_word_q[{s0_lane_q, 3'b000} +: 8];
    s0_half = s0_lane_q[1] ? s0_word_q[31:16] : s0_word_q[15:0];
    s0_fmt  = '0;
    if (s0_valid_q & s0_load_q & ~s0_err_q) begin
      unique case (s0_f3_q)
        3'b000:  s0_fmt = {{24{s0_byte[7]}}, s0_byte};
        3'b100:  s0_fmt = {24'b0, s0_byte};
        3'b001:  s0_fmt = {{16{s0_half[15]}}, s0_half};
        3'b101:  s0_fmt = {16'b0, s0_half};
        default: s0_fmt = s0_word_q;
      endcase
    end
  end

  generate
    if (READ_LAT == 1) begin : g_direct
      assign rsp_valid = s0_valid_q;
      assign rsp_err   = s0_err_q;
      assign rsp_rdata = s0_fmt;
    end else begin : g_delay
      logic [READ_LAT-2:0] d_valid_q, d_err_q;
      logic [31:0]         d_rdata_q [READ_LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_valid_q <= '0;
          d_err_q   <= '0;
          for (int i = 0; i < READ_LAT - 1; i++) d_rdata_q[i] <= '0;
        end else begin
          d_valid_q[0] <= s0_valid_q;
          d_err_q[0]   <= s0_err_q;
          d_rdata_q[0] <= s0_fmt;
          for (int i = 1; i < READ_LAT - 1; i++) begin
            d_valid_q[i] <= d_valid_q[i-1];
            d_err_q[i]   <= d_err_q[i-1];
            d_rdata_q[i] <= d_rdata_q[i-1];
          end
        end
      end

      assign rsp_valid = d_valid_q[READ_LAT-2];
      assign rsp_err   = d_err_q[READ_LAT-2];
      assign rsp_rdata = d_rdata_q[READ_LAT-2];
    end
  endgenerate

endmodule
